// File: rtl/load_hazard_ctrl.sv
// Interlock controller for the 3-stage ID/EX/WB pipeline. It tracks outstanding
// multi-cycle loads in a per-register scoreboard. It stalls ID on dependences
// that forwarding cannot cover, and it flushes wrong-path fetches after a taken
// branch.
module load_hazard_ctrl #(
    parameter int NREG         = 8,
    parameter int ADDR_W       = 3,
    parameter int MAX_LOADS    = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_use_rs,
    input  logic              id_use_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              ld_done,
    input  logic [ADDR_W-1:0] ld_rd,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [NREG-1:0]   pending,
    output logic              ld_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd2
    } state_t;

    // The load counter gets one spare code so that it can never wrap.
    localparam int LC_W = $clog2(MAX_LOADS + 2);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [LC_W-1:0] LC_MAX  = LC_W'(MAX_LOADS);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [LC_W-1:0]   lcnt_q, lcnt_d;
    logic [NREG-1:0]   ld_mask, iss_mask, eff;
    logic              hazard, redirect, issue, ld_ok;

    assign state = state_q;

    // Build the effective scoreboard. A load that returns this cycle no longer
    // blocks, because forwarding delivers its data.
    always_comb begin
        ld_mask = '0;
        if (ld_done) ld_mask[ld_rd] = 1'b1;
        eff   = pending & ~ld_mask;
        ld_ok = ld_done & pending[ld_rd];
    end

    // Detect hazards, redirects and load issue.
    always_comb begin
        hazard = id_valid & ((id_use_rs & eff[id_rs]) |
                             (id_use_rd & eff[id_rd]) |
                             (id_reg_write & eff[id_rd]) |
                             (id_is_load & (lcnt_q == LC_MAX) & ~ld_done));
        redirect = ex_branch_taken | (state_q == FLUSH);
        issue    = id_valid & id_is_load & ~hazard & ~redirect;
        iss_mask = '0;
        if (issue) iss_mask[id_rd] = 1'b1;
    end

    // Drive the pipeline controls. A redirect overrides a stall, and reset forces a bubble.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Compute the next flush-FSM state. A taken branch while in FLUSH restarts the count.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (ex_branch_taken && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_LOAD;
                end
            end
            FLUSH: begin
                if (ex_branch_taken) fcnt_d = FC_LOAD;
                else if (fcnt_q == '0) state_d = RUN;
                else fcnt_d = fcnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Compute the next outstanding-load count. An issue and a valid return in the same cycle cancel out.
    always_comb begin
        lcnt_d = lcnt_q;
        if (issue && !ld_ok) lcnt_d = lcnt_q + 1'b1;
        else if (!issue && ld_ok) lcnt_d = lcnt_q - 1'b1;
    end

    // Hold the FSM state and the flush counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Update the scoreboard. The issue set is applied after the return clear,
    // so an issue to the same register keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            lcnt_q  <= '0;
        end else begin
            pending <= (pending & ~ld_mask) | iss_mask;
            lcnt_q  <= lcnt_d;
        end
    end

    // Set the sticky error flag when a load returns for a register with no outstanding load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ld_err <= 1'b0;
        else if (ld_done && !pending[ld_rd]) ld_err <= 1'b1;
    end

    // Count hazard-stall cycles, saturating at all-ones. Redirect cycles are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (hazard && !redirect && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
